// File: rtl/dc_sched_pkg.sv
// dc_sched_pkg
// Shared widths, the scheduler FSM state encoding and the packed codeword
// record carried through the codeword FIFO.
package dc_sched_pkg;

  localparam int DC_W   = 20;  // DC coefficient, two's complement
  localparam int CODE_W = 24;  // right-aligned codeword
  localparam int LEN_W  = 5;   // codeword length 1..24
  localparam int BITS_W = 16;  // per-slice bit total (saturating)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
    logic              last;
  } codeword_t;

  localparam int CW_W = $bits(codeword_t);

endpackage

// File: rtl/dc_code_fifo.sv
// dc_code_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever empty is low; rd_en pops it. A write into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is dropped.
// rd_data reads as zero while empty so downstream sees clean reset values.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   wr_en, wr_data  push request and data
//   rd_en           pop the head (ignored when empty)
//   rd_data         head entry
//   empty, full     occupancy flags
//   count           number of stored entries, 0..DEPTH
module dc_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/dc_slice_scheduler.sv
// dc_slice_scheduler
// Walks one slice's DC coefficients: reads each block's DC value from the
// coefficient buffer, presents it to the (non-stallable) DC encoder with a
// first-of-slice flag, collects the returned codewords in a FIFO and offers
// them to the bitstream packer. A read is launched only while the FIFO has
// room for every result already in the encoder pipe plus this one (credit).
//
// Handshake on the packer side: out_code/out_len/out_last are valid while
// out_valid is high and are held until the cycle out_valid && out_ready,
// in which the head is consumed; out_valid never depends on out_ready.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, num_blocks           slice launch (IDLE only) and block count
//   busy, done                  slice in progress / one-cycle end pulse
//   slice_dc_bits               saturating sum of codeword lengths
//   err                         sticky: stray codeword or FIFO overflow
//   coef_rd_en/addr/data        coefficient buffer read port (1-cycle data)
//   enc_valid/first/dc          encoder input
//   enc_code_valid/code/len     encoder result
//   out_valid/code/len/last     packer output, out_ready accepts
//   dbg_state                   current FSM state (state_t encoding)
module dc_slice_scheduler
  import dc_sched_pkg::*;
#(
  parameter int MAX_BLOCKS  = 32,
  parameter int ADDR_W      = 5,
  parameter int ENC_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_blocks,
  output logic              busy,
  output logic              done,
  output logic [BITS_W-1:0] slice_dc_bits,
  output logic              err,
  output logic              coef_rd_en,
  output logic [ADDR_W-1:0] coef_rd_addr,
  input  logic [DC_W-1:0]   coef_rd_data,
  output logic              enc_valid,
  output logic              enc_first,
  output logic [DC_W-1:0]   enc_dc,
  input  logic              enc_code_valid,
  input  logic [CODE_W-1:0] enc_code,
  input  logic [LEN_W-1:0]  enc_code_len,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] MAXB_V  = (ADDR_W + 1)'(MAX_BLOCKS);
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);

  // A FIFO shallower than the encoder pipe plus two is still safe (credit
  // throttles issue) but cannot sustain one block per cycle.
  if (FIFO_DEPTH < ENC_LATENCY + 2) begin : g_depth_below_latency
  end

  state_t            state_q, state_d;
  logic [ADDR_W:0]   nb_q, nb_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic [ADDR_W:0]   rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [BITS_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
  logic              enc_valid_q, enc_valid_d;
  logic              enc_first_q, enc_first_d;

  logic              start_acc;
  logic              has_credit;
  logic [CNT_W:0]    used;
  logic              code_accept;
  logic              err_event;
  logic              pop;
  logic              last_pop;
  logic [BITS_W:0]   sum_ext;

  codeword_t         wr_cw;
  codeword_t         head_cw;
  logic [CW_W-1:0]   fifo_rd_data;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_blocks == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (coef_rd_en && (rd_idx_q == nb_q - ONE_V)) state_d = ST_DRAIN;
      ST_DRAIN: if (last_pop) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    coef_rd_en = (state_q == ST_ISSUE) && has_credit;
  end

  assign dbg_state = state_q;

  // ------------------------------------------------------- credit / issue
  // Slots already spoken for: words sitting in the FIFO plus words the
  // encoder still owes us.
  assign used       = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign has_credit = (used < DEPTH_V);
  assign start_acc  = start && (state_q == ST_IDLE);

  // A codeword with nothing outstanding is a protocol error and is dropped.
  assign code_accept = enc_code_valid && (inflight_q != '0);
  assign pop         = out_valid && out_ready;
  assign last_pop    = pop && out_last;
  assign err_event   = (enc_code_valid && (inflight_q == '0))
                     || (code_accept && fifo_full && !pop);
  assign sum_ext     = {1'b0, sum_q} + (BITS_W + 1)'(enc_code_len);

  always_comb begin
    nb_d        = nb_q;
    rd_idx_d    = rd_idx_q;
    rx_cnt_d    = rx_cnt_q;
    sum_d       = sum_q;
    err_d       = err_q;
    inflight_d  = inflight_q;
    enc_valid_d = coef_rd_en;
    enc_first_d = coef_rd_en && (rd_idx_q == '0);

    if (start_acc) begin
      nb_d     = (num_blocks > MAXB_V) ? MAXB_V : num_blocks;
      rd_idx_d = '0;
      rx_cnt_d = '0;
      sum_d    = '0;
      err_d    = 1'b0;
    end else begin
      if (coef_rd_en) rd_idx_d = rd_idx_q + ONE_V;
      if (code_accept) begin
        rx_cnt_d = rx_cnt_q + ONE_V;
        sum_d    = sum_ext[BITS_W] ? '1 : sum_ext[BITS_W-1:0];
      end
      err_d = err_q || err_event;
    end

    // Issue and receive in the same cycle leave the count unchanged.
    case ({coef_rd_en, code_accept})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nb_q        <= '0;
      rd_idx_q    <= '0;
      rx_cnt_q    <= '0;
      inflight_q  <= '0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      enc_valid_q <= 1'b0;
      enc_first_q <= 1'b0;
    end else begin
      nb_q        <= nb_d;
      rd_idx_q    <= rd_idx_d;
      rx_cnt_q    <= rx_cnt_d;
      inflight_q  <= inflight_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      enc_valid_q <= enc_valid_d;
      enc_first_q <= enc_first_d;
    end
  end

  // Buffer data arrives the cycle after the read, aligned with enc_valid_q.
  assign coef_rd_addr = rd_idx_q[ADDR_W-1:0];
  assign enc_valid    = enc_valid_q;
  assign enc_first    = enc_first_q;
  assign enc_dc       = enc_valid_q ? coef_rd_data : '0;

  // ---------------------------------------------------------- codeword FIFO
  always_comb begin
    wr_cw.code = enc_code;
    wr_cw.len  = enc_code_len;
    wr_cw.last = (rx_cnt_q == nb_q - ONE_V);
  end

  dc_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CW_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (code_accept),
    .wr_data (wr_cw),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign head_cw       = codeword_t'(fifo_rd_data);
  assign out_valid     = !fifo_empty;
  assign out_code      = head_cw.code;
  assign out_len       = head_cw.len;
  assign out_last      = head_cw.last;
  assign slice_dc_bits = sum_q;
  assign err           = err_q;

endmodule

// File: tb/tb_dc_slice_scheduler.sv
// Directed bench for dc_slice_scheduler with a coefficient-buffer model and a
// fixed-latency encoder model (code = {4'hA, dc}, len = dc[3:0] + 1).
module tb_dc_slice_scheduler;

  localparam int L      = 4;
  localparam int ADDR_W = 5;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              reset, start, out_ready, inj;
  logic [ADDR_W:0]   num_blocks;
  logic              busy, done, err, coef_rd_en;
  logic [15:0]       slice_dc_bits;
  logic [ADDR_W-1:0] coef_rd_addr;
  logic [19:0]       coef_rd_data;
  logic              enc_valid, enc_first;
  logic [19:0]       enc_dc;
  logic              enc_code_valid;
  logic [23:0]       enc_code;
  logic [4:0]        enc_code_len;
  logic              out_valid, out_last;
  logic [23:0]       out_code;
  logic [4:0]        out_len;
  logic [1:0]        dbg_state;

  dc_slice_scheduler #(
    .MAX_BLOCKS (32), .ADDR_W (ADDR_W), .ENC_LATENCY (L), .FIFO_DEPTH (8)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .num_blocks (num_blocks),
    .busy (busy), .done (done), .slice_dc_bits (slice_dc_bits), .err (err),
    .coef_rd_en (coef_rd_en), .coef_rd_addr (coef_rd_addr),
    .coef_rd_data (coef_rd_data), .enc_valid (enc_valid),
    .enc_first (enc_first), .enc_dc (enc_dc),
    .enc_code_valid (enc_code_valid), .enc_code (enc_code),
    .enc_code_len (enc_code_len), .out_valid (out_valid),
    .out_code (out_code), .out_len (out_len), .out_last (out_last),
    .out_ready (out_ready), .dbg_state (dbg_state)
  );

  // ------------------------------------------------------------ models
  function automatic logic [23:0] code_fn(input logic [19:0] dc);
    return {4'hA, dc};
  endfunction
  function automatic logic [4:0] len_fn(input logic [19:0] dc);
    return {1'b0, dc[3:0]} + 5'd1;
  endfunction

  logic [19:0] coef_mem [32];
  always @(posedge clk) begin
    if (reset)           coef_rd_data <= '0;
    else if (coef_rd_en) coef_rd_data <= coef_mem[coef_rd_addr];
  end

  logic        pv [L];
  logic [19:0] pd [L];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= enc_valid;
      pd[0] <= enc_dc;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign enc_code_valid = pv[L-1] | inj;
  assign enc_code       = inj ? 24'hDEAD01 : code_fn(pd[L-1]);
  assign enc_code_len   = inj ? 5'd9 : len_fn(pd[L-1]);

  // ------------------------------------------------- monitor (logs only)
  int          rd_log[$], enc_log[$], ov_log[$], done_log[$];
  logic [19:0] first_dc_log[$];
  logic [29:0] word_log[$];
  int          busy_total = 0;

  always @(negedge clk) begin
    if (coef_rd_en) rd_log.push_back(cyc);
    if (enc_valid) enc_log.push_back(cyc);
    if (enc_valid && enc_first) first_dc_log.push_back(enc_dc);
    if (out_valid) ov_log.push_back(cyc);
    if (out_valid && out_ready) word_log.push_back({out_code, out_len, out_last});
    if (busy) busy_total++;
    if (done) done_log.push_back(cyc);
  end

  // -------------------------------------------------------- scoreboard
  logic [29:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int b_rd, b_enc, b_first, b_ov, b_word, b_done, b_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snapshot();
    b_rd = rd_log.size(); b_enc = enc_log.size(); b_first = first_dc_log.size();
    b_ov = ov_log.size(); b_word = word_log.size(); b_done = done_log.size();
    b_busy = busy_total;
  endtask

  function automatic int first_of(input int q[$], input int base);
    return (q.size() > base) ? q[base] : -1;
  endfunction

  // Drives a one-cycle start; t0 is the cycle number whose closing edge samples it.
  task automatic start_slice(input int nb, output int t0);
    snapshot();
    start = 1'b1;
    num_blocks = (ADDR_W + 1)'(nb);
    t0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_log.size() == b_done && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_log.size() > b_done), 32'd1);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_word_count"}, 32'(word_log.size() - b_word), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (b_word + i < word_log.size())
        chk($sformatf("%s_word%0d", tag, i), 32'(word_log[b_word + i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_coef_rd_en"}, 32'(coef_rd_en), 0);
    chk({tag, "_coef_rd_addr"}, 32'(coef_rd_addr), 0);
    chk({tag, "_enc_valid"}, 32'(enc_valid), 0);
    chk({tag, "_enc_first"}, 32'(enc_first), 0);
    chk({tag, "_enc_dc"}, 32'(enc_dc), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_out_code"}, 32'(out_code), 0);
    chk({tag, "_out_len"}, 32'(out_len), 0);
    chk({tag, "_slice_dc_bits"}, 32'(slice_dc_bits), 0);
    chk({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    int t0;
    int exp_sum;
    logic [19:0] dc;

    reset = 1'b1; start = 1'b0; out_ready = 1'b1; inj = 1'b0; num_blocks = '0;
    for (int i = 0; i < 32; i++) coef_mem[i] = '0;
    tick(3);

    // 1. reset values
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(1);

    // 2. four blocks, packer always ready; words sum to 5+5+6+4 = 20
    coef_mem[0] = 20'd100; coef_mem[1] = 20'd100;
    coef_mem[2] = 20'd101; coef_mem[3] = 20'd99;
    exp_q.delete();
    for (int i = 0; i < 4; i++)
      exp_q.push_back({code_fn(coef_mem[i]), len_fn(coef_mem[i]), i == 3});
    start_slice(4, t0);
    wait_done("s4", 100);
    chk("s4_first_rd_cyc", 32'(first_of(rd_log, b_rd) - t0), 32'd1);
    chk("s4_first_enc_cyc", 32'(first_of(enc_log, b_enc) - t0), 32'd2);
    chk("s4_first_ov_cyc", 32'(first_of(ov_log, b_ov) - t0), 32'd7);
    chk("s4_done_cyc", 32'(first_of(done_log, b_done) - t0), 32'd11);
    chk("s4_rd_count", 32'(rd_log.size() - b_rd), 32'd4);
    chk("s4_enc_count", 32'(enc_log.size() - b_enc), 32'd4);
    chk("s4_first_count", 32'(first_dc_log.size() - b_first), 32'd1);
    if (first_dc_log.size() > b_first)
      chk("s4_first_dc", 32'(first_dc_log[b_first]), 32'd100);
    check_words("s4");
    chk("s4_bits", 32'(slice_dc_bits), 32'd20);
    chk("s4_busy_cycles", 32'(busy_total - b_busy), 32'd11);
    chk("s4_err", 32'(err), 0);
    chk("s4_idle_busy", 32'(busy), 0);

    // 3. 32 blocks with the packer stalled for 20 cycles; a second start
    //    arrives mid-slice and must be ignored
    exp_q.delete();
    exp_sum = 0;
    for (int i = 0; i < 32; i++) begin
      dc = 20'(i * 4099 + 7);
      coef_mem[i] = dc;
      exp_q.push_back({code_fn(dc), len_fn(dc), i == 31});
      exp_sum += int'(len_fn(dc));
    end
    out_ready = 1'b0;
    start_slice(32, t0);
    tick(6);
    start = 1'b1; num_blocks = 6'd3;
    tick(1);
    start = 1'b0;
    tick(12);
    chk("s32_stalled_reads", 32'(rd_log.size() - b_rd), 32'd8);
    chk("s32_stalled_err", 32'(err), 0);
    chk("s32_stalled_out_valid", 32'(out_valid), 1);
    chk("s32_stalled_busy", 32'(busy), 1);
    out_ready = 1'b1;
    wait_done("s32", 400);
    chk("s32_rd_count", 32'(rd_log.size() - b_rd), 32'd32);
    chk("s32_first_count", 32'(first_dc_log.size() - b_first), 32'd1);
    check_words("s32");
    chk("s32_bits", 32'(slice_dc_bits), 32'(exp_sum));
    chk("s32_err", 32'(err), 0);
    chk("s32_done_pulses", 32'(done_log.size() - b_done), 32'd1);

    // 4. empty slice
    exp_q.delete();
    start_slice(0, t0);
    wait_done("s0", 10);
    chk("s0_done_cyc", 32'(first_of(done_log, b_done) - t0), 32'd1);
    chk("s0_busy_cycles", 32'(busy_total - b_busy), 32'd1);
    chk("s0_rd_count", 32'(rd_log.size() - b_rd), 0);
    chk("s0_bits", 32'(slice_dc_bits), 0);
    check_words("s0");

    // 5. reset in cycle 5 of a 16-block slice, then a 2-block slice (16+1 bits)
    for (int i = 0; i < 16; i++) coef_mem[i] = 20'(i * 77 + 3);
    start_slice(16, t0);
    tick(4);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("midrst");
    reset = 1'b0;
    tick(1);
    coef_mem[0] = 20'hFFFFF; coef_mem[1] = 20'h80000;
    exp_q.delete();
    exp_q.push_back({24'hAFFFFF, 5'd16, 1'b0});
    exp_q.push_back({24'hA80000, 5'd1, 1'b1});
    start_slice(2, t0);
    wait_done("s2", 100);
    chk("s2_done_cyc", 32'(first_of(done_log, b_done) - t0), 32'd9);
    check_words("s2");
    chk("s2_bits", 32'(slice_dc_bits), 32'd17);
    chk("s2_err", 32'(err), 0);

    // 6. stray codeword while idle sets err without a FIFO write
    tick(2);
    inj = 1'b1;
    tick(1);
    inj = 1'b0;
    chk("stray_err", 32'(err), 1);
    chk("stray_out_valid", 32'(out_valid), 0);
    tick(2);
    chk("stray_err_sticky", 32'(err), 1);
    coef_mem[0] = 20'h12345;
    exp_q.delete();
    exp_q.push_back({24'hA12345, 5'd6, 1'b1});
    start_slice(1, t0);
    chk("stray_err_cleared", 32'(err), 0);
    wait_done("s1", 100);
    chk("s1_done_cyc", 32'(first_of(done_log, b_done) - t0), 32'd8);
    check_words("s1");
    chk("s1_bits", 32'(slice_dc_bits), 32'd6);
    chk("s1_err", 32'(err), 0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
